// File: rtl/instruction_decoder_pipe.sv
// Splits instruction words into opcode/register/flag/immediate fields and buffers them in a DEPTH-entry FIFO.
// Latency: a word pushed into an empty FIFO is presented on the outputs the following cycle; throughput one per cycle.
// Backpressure: in_ready drops only when the FIFO is full (never from out_ready); enable=0 freezes both sides.
// Optional feature: define INSTR_DECODER_ILLEGAL_CHECK_EN to flag opcodes absent from LEGAL_MASK and count them.
module instruction_decoder_pipe #(
    parameter int OPC_W = 4,
    parameter int REG_W = 3,
    parameter int IMM_W = 8,
    parameter int DEPTH = 2,
    parameter logic [2**OPC_W-1:0] LEGAL_MASK = {2**OPC_W{1'b1}},
    localparam int IW    = OPC_W + REG_W + 1 + IMM_W,
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    instruct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPC_W-1:0] opcode,
    output logic [REG_W-1:0] rDadrs,
    output logic             flag,
    output logic [REG_W-1:0] rAadrs,
    output logic [REG_W-1:0] rBadrs,
    output logic [IMM_W-1:0] imm,
    output logic             illegal,
    output logic [15:0]      err_count,
    output logic [OCC_W-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    // rA/rB overlap the immediate bits, so only the immediate is stored and
    // the two source addresses are re-sliced from it at the head.
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic             flag;
        logic [IMM_W-1:0] imm;
`ifdef INSTR_DECODER_ILLEGAL_CHECK_EN
        logic             illegal;
`endif
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            push_entry;
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              push;
    logic              pop;

    // Handshakes: ready depends only on local state, never on out_ready.
    assign in_ready  = enable && !reset && (occ != FULL_OCC);
    assign out_valid = enable && !reset && (occ != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = occ;
    assign head      = mem[rd_ptr];

    // Decode the incoming word into its stored fields.
    always_comb begin
        push_entry        = '0;
        push_entry.opcode = instruct[IW-1 -: OPC_W];
        push_entry.rd     = instruct[IMM_W+REG_W -: REG_W];
        push_entry.flag   = instruct[IMM_W];
        push_entry.imm    = instruct[IMM_W-1:0];
`ifdef INSTR_DECODER_ILLEGAL_CHECK_EN
        push_entry.illegal = !LEGAL_MASK[instruct[IW-1 -: OPC_W]];
`endif
    end

    // Entry storage; contents need no reset because outputs are masked by out_valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Read/write pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy tracks push/pop; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            occ <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef INSTR_DECODER_ILLEGAL_CHECK_EN
    logic [15:0] err_q;

    // Count accepted illegal opcodes, sticking at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= '0;
        end else if (push && push_entry.illegal && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
    assign illegal   = out_valid && head.illegal;
`else
    // Without the check the mask has no effect; fold it into a dead net.
    logic unused_legal_mask;
    assign unused_legal_mask = ^LEGAL_MASK;
    assign err_count         = 16'h0000;
    assign illegal           = 1'b0;
`endif

    // Present the head entry, zeroed whenever nothing is being offered.
    always_comb begin
        opcode = '0;
        rDadrs = '0;
        flag   = 1'b0;
        rAadrs = '0;
        rBadrs = '0;
        imm    = '0;
        if (out_valid) begin
            opcode = head.opcode;
            rDadrs = head.rd;
            flag   = head.flag;
            rAadrs = head.imm[IMM_W-1 -: REG_W];
            rBadrs = head.imm[IMM_W-1-REG_W -: REG_W];
            imm    = head.imm;
        end
    end

endmodule

// File: tb/tb_instruction_decoder_pipe.sv
module tb_instruction_decoder_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instruct;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [2:0]  rDadrs;
    logic        flag;
    logic [2:0]  rAadrs;
    logic [2:0]  rBadrs;
    logic [7:0]  imm;
    logic        illegal;
    logic [15:0] err_count;
    logic [1:0]  occupancy;

    int tests = 0;
    int fails = 0;

`ifdef INSTR_DECODER_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    always #5 clock = ~clock;

    instruction_decoder_pipe #(.LEGAL_MASK(16'h7FFF)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .instruct(instruct),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rDadrs(rDadrs), .flag(flag),
        .rAadrs(rAadrs), .rBadrs(rBadrs), .imm(imm),
        .illegal(illegal), .err_count(err_count), .occupancy(occupancy)
    );

    // Inputs change at the falling edge and outputs are sampled there too.
    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [15:0] head_word();
        return {opcode, rDadrs, flag, imm};
    endfunction

    function automatic logic [15:0] stream_word(input int i);
        return {4'(i % 8), 12'(i * 32'h135 + 32'h42)};
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1; instruct = 16'hA5C3;
        tick(); tick();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL rst_occ: got %0d expected 0", occupancy); end
        tests++; if (opcode !== 4'h0 || imm !== 8'h00) begin fails++; $display("FAIL rst_fields: got opc %h imm %h expected 0 0", opcode, imm); end
        tests++; if (err_count !== 16'h0) begin fails++; $display("FAIL rst_err: got %h expected 0", err_count); end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic_decode();
        in_valid = 1'b1; instruct = 16'hA5C3; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL dec_valid: got %b expected 1", out_valid); end
        tests++; if (opcode !== 4'hA) begin fails++; $display("FAIL dec_opcode: got %h expected a", opcode); end
        tests++; if (rDadrs !== 3'b010) begin fails++; $display("FAIL dec_rd: got %b expected 010", rDadrs); end
        tests++; if (flag !== 1'b1) begin fails++; $display("FAIL dec_flag: got %b expected 1", flag); end
        tests++; if (rAadrs !== 3'b110) begin fails++; $display("FAIL dec_ra: got %b expected 110", rAadrs); end
        tests++; if (rBadrs !== 3'b000) begin fails++; $display("FAIL dec_rb: got %b expected 000", rBadrs); end
        tests++; if (imm !== 8'hC3) begin fails++; $display("FAIL dec_imm: got %h expected c3", imm); end
        tests++; if (occupancy !== 2'd1) begin fails++; $display("FAIL dec_occ: got %0d expected 1", occupancy); end
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL dec_illegal: got %b expected 0", illegal); end
        tick();
        tests++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin fails++; $display("FAIL dec_drained: got valid %b occ %0d expected 0 0", out_valid, occupancy); end
        tests++; if (opcode !== 4'h0 || imm !== 8'h00) begin fails++; $display("FAIL dec_masked: got opc %h imm %h expected 0 0", opcode, imm); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; instruct = 16'h1234;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready0: got %b expected 1", in_ready); end
        tick();
        instruct = 16'h2345;
        tick();
        instruct = 16'h3456;
        tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL bp_occ_full: got %0d expected 2", occupancy); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
        tick();
        tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL bp_occ_hold: got %0d expected 2", occupancy); end
        out_ready = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b1 || head_word() !== 16'h1234) begin fails++; $display("FAIL bp_first: got %b %h expected 1 1234", out_valid, head_word()); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_indep: got %b expected 0", in_ready); end
        tick();
        tests++; if (occupancy !== 2'd1 || head_word() !== 16'h2345) begin fails++; $display("FAIL bp_second: got occ %0d %h expected 1 2345", occupancy, head_word()); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_free: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests++; if (occupancy !== 2'd1 || head_word() !== 16'h3456) begin fails++; $display("FAIL bp_third: got occ %0d %h expected 1 3456", occupancy, head_word()); end
        tick();
        tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got occ %0d valid %b expected 0 0", occupancy, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_q[$];
        int nxt = 0;
        bit do_push;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instruct = stream_word(nxt);
            exp_q.push_back(instruct);
            nxt++;
            tick();
        end
        out_ready = 1'b1;
        instruct = stream_word(nxt);
        for (int c = 0; c < 14; c++) begin
            #1;
            tests++; if (occupancy !== 2'(exp_q.size())) begin fails++; $display("FAIL b2b_occ[%0d]: got %0d expected %0d", c, occupancy, exp_q.size()); end
            tests++; if (in_ready !== (exp_q.size() < 2)) begin fails++; $display("FAIL b2b_ready[%0d]: got %b expected %b", c, in_ready, exp_q.size() < 2); end
            tests++; if (out_valid !== 1'b1 || head_word() !== exp_q[0]) begin fails++; $display("FAIL b2b_head[%0d]: got %b %h expected 1 %h", c, out_valid, head_word(), exp_q[0]); end
            do_push = (exp_q.size() < 2);
            void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back(instruct);
                nxt++;
            end
            tick();
            instruct = stream_word(nxt);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4 && exp_q.size() > 0; c++) begin
            #1;
            tests++; if (out_valid !== 1'b1 || head_word() !== exp_q[0]) begin fails++; $display("FAIL b2b_drain[%0d]: got %b %h expected 1 %h", c, out_valid, head_word(), exp_q[0]); end
            void'(exp_q.pop_front());
            tick();
        end
        tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL b2b_empty: got %0d expected 0", occupancy); end
    endtask

    task automatic test_enable();
        out_ready = 1'b0; in_valid = 1'b1; instruct = 16'h7ABC;
        tick();
        in_valid = 1'b0; enable = 1'b0; out_ready = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL en_off_hs: got valid %b ready %b expected 0 0", out_valid, in_ready); end
        tests++; if (opcode !== 4'h0 || imm !== 8'h00) begin fails++; $display("FAIL en_off_mask: got opc %h imm %h expected 0 0", opcode, imm); end
        tick(); tick();
        tests++; if (occupancy !== 2'd1) begin fails++; $display("FAIL en_off_hold: got %0d expected 1", occupancy); end
        enable = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b1 || head_word() !== 16'h7ABC) begin fails++; $display("FAIL en_on_head: got %b %h expected 1 7abc", out_valid, head_word()); end
        tick();
        tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL en_on_pop: got %0d expected 0", occupancy); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0; in_valid = 1'b1; instruct = 16'hF123;
        tick();
        instruct = 16'hF456;
        tests++; if (illegal !== ILL_EN) begin fails++; $display("FAIL ill_first: got %b expected %b", illegal, ILL_EN); end
        tests++; if (err_count !== 16'(ILL_EN ? 1 : 0)) begin fails++; $display("FAIL ill_cnt1: got %0d expected %0d", err_count, ILL_EN ? 1 : 0); end
        tick();
        in_valid = 1'b0;
        tests++; if (err_count !== 16'(ILL_EN ? 2 : 0)) begin fails++; $display("FAIL ill_cnt2: got %0d expected %0d", err_count, ILL_EN ? 2 : 0); end
        tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL ill_occ: got %0d expected 2", occupancy); end
        out_ready = 1'b1;
        tick();
        tests++; if (head_word() !== 16'hF456 || illegal !== ILL_EN) begin fails++; $display("FAIL ill_second: got %h %b expected f456 %b", head_word(), illegal, ILL_EN); end
        tick();
        tests++; if (out_valid !== 1'b0 || illegal !== 1'b0) begin fails++; $display("FAIL ill_masked: got valid %b ill %b expected 0 0", out_valid, illegal); end
        tests++; if (err_count !== 16'(ILL_EN ? 2 : 0)) begin fails++; $display("FAIL ill_cnt_hold: got %0d expected %0d", err_count, ILL_EN ? 2 : 0); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; instruct = 16'h3C5A;
        tick();
        instruct = 16'h4D6B;
        tick();
        in_valid = 1'b0;
        tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL rmid_full: got %0d expected 2", occupancy); end
        reset = 1'b1;
        tick();
        tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL rmid_state: got occ %0d valid %b ready %b expected 0 0 0", occupancy, out_valid, in_ready); end
        tests++; if ({opcode, rDadrs, flag, rAadrs, rBadrs, imm, illegal} !== '0) begin fails++; $display("FAIL rmid_fields: got %h expected 0", {opcode, rDadrs, flag, rAadrs, rBadrs, imm, illegal}); end
        tests++; if (err_count !== 16'h0) begin fails++; $display("FAIL rmid_err: got %0d expected 0", err_count); end
        reset = 1'b0;
        tick();
        tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL rmid_discard: got occ %0d valid %b expected 0 0", occupancy, out_valid); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruct = 16'h0;
        test_reset();
        test_basic_decode();
        test_backpressure();
        test_back_to_back();
        test_enable();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_decoder_pipe.md
# instruction_decoder_pipe

Parametrised, handshaked successor to the 16-bit instruction decoder. Splits each instruction word into opcode, destination/source register addresses, flag bit and immediate. Decoded words are buffered in a DEPTH-entry FIFO with valid/ready on both sides, so fetch and issue can stall independently. Sits between instruction fetch and register-file read/issue.

## Interface
Parameters:
- OPC_W, default 4, opcode width.
- REG_W, default 3, register address width.
- IMM_W, default 8, immediate width; must satisfy IMM_W >= 2*REG_W.
- DEPTH, default 2, FIFO entries; power of two, >= 2.
- LEGAL_MASK, default {2**OPC_W{1'b1}}, bit k set means opcode k is legal.
- Derived IW = OPC_W + REG_W + 1 + IMM_W (16 at defaults).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global advance; low freezes both handshakes
- in_valid  in  1  instruct is presented
- in_ready  out  1  decoder accepts this cycle
- instruct  in  IW  instruction word
- out_valid  out  1  head entry is presented
- out_ready  in  1  consumer takes head entry
- opcode  out  OPC_W  instruct[IW-1 -: OPC_W]
- rDadrs  out  REG_W  instruct[IMM_W+REG_W -: REG_W]
- flag  out  1  instruct[IMM_W]
- rAadrs  out  REG_W  instruct[IMM_W-1 -: REG_W]
- rBadrs  out  REG_W  instruct[IMM_W-1-REG_W -: REG_W]
- imm  out  IMM_W  instruct[IMM_W-1:0]
- illegal  out  1  head opcode not in LEGAL_MASK
- err_count  out  16  accepted illegal instructions, saturating
- occupancy  out  $clog2(DEPTH)+1  entries held

## Operation
- Push when in_valid && in_ready; in_ready = enable && (occupancy != DEPTH). in_ready never depends on out_ready.
- Pop when out_valid && out_ready; out_valid = enable && (occupancy != 0).
- Push and pop in the same cycle: occupancy unchanged, both happen; legal when full (pop frees, push refills) only if in_ready was already high, i.e. not full.
- Fields are decoded at push and stored per entry; outputs show the head entry (read pointer). When out_valid=0 all field outputs and illegal are 0.
- Pointers wrap modulo DEPTH; occupancy ranges 0..DEPTH.
- enable=0: no push, no pop, storage and counters hold; in_ready=0, out_valid=0.
- reset: occupancy=0, pointers=0, out_valid=0, in_ready=0 during reset, all field outputs 0, illegal=0, err_count=0. Reset mid-stream discards all buffered entries.

## Timing
- Latency: instruction pushed in cycle N is visible at outputs in cycle N+1 if FIFO was empty; otherwise behind older entries.
- Throughput: one instruction per cycle when out_ready held high.
- occupancy and err_count update on the clock edge of the push/pop.
- All outputs except the zero-masking of fields by out_valid come from registers; no combinational path instruct -> outputs, out_ready -> in_ready.

## Configuration
- Macro INSTR_DECODER_ILLEGAL_CHECK_EN.
- Defined: each entry stores !LEGAL_MASK[opcode]; illegal reflects head entry; err_count increments by 1 on each push whose opcode is illegal, saturating at 16'hFFFF. Illegal instructions are still buffered and delivered.
- Undefined: illegal tied 0, err_count tied 0, LEGAL_MASK ignored; no extra storage bit.

## Test plan
- Defaults, out_ready=1, push 16'hA5C3 -> next cycle out_valid=1, opcode=4'hA, rDadrs=3'b010, flag=1, rAadrs=3'b110, rBadrs=3'b000, imm=8'hC3.
- out_ready=0, push 3 words with DEPTH=2 -> in_ready=0 after 2nd push, occupancy=2; release out_ready -> words delivered in push order, none lost or duplicated.
- Full FIFO, out_ready=1 and in_valid=1 continuously -> one pop per cycle, in_ready high on cycles with occupancy<2, order preserved across pointer wrap (≥10 words).
- enable=0 with occupancy=1 and out_ready=1 -> out_valid=0, in_ready=0, occupancy stays 1; enable=1 -> entry delivered.
- Reset asserted with occupancy=2 -> next cycle occupancy=0, out_valid=0, all fields 0, err_count=0.
- Macro defined, LEGAL_MASK=16'h7FFF, push opcode 4'hF twice -> illegal=1 at head for each, err_count=2; macro undefined -> illegal=0, err_count=0.
